// File: rtl/usb_reg_bank.sv
// usb_reg_bank: register bank behind usb_if. Provides NUM_REGS host-writable control
// registers with one-cycle write strobes, a sticky write-1-to-clear status register,
// a device-to-host byte FIFO drained by host reads and an optional firmware ID string.
// Optional feature macro: USB_REGB_FWID_EN builds the 16-byte firmware ID ROM at
// FW_BASE..FW_BASE+15. When the macro is undefined that range reads 0x00.
module usb_reg_bank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 8'hE0,
    parameter logic [ADDR_WIDTH-1:0] FIFO_ADDR   = 8'hE1,
    parameter logic [ADDR_WIDTH-1:0] FCNT_ADDR   = 8'hE2
`ifdef USB_REGB_FWID_EN
    ,
    parameter logic [ADDR_WIDTH-1:0] FW_BASE = 8'hF0,
    parameter logic [127:0]          FW_ID   = "WOKAR_REGB_2.000"
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           if_wr,
    input  logic                           if_rd,
    input  logic [ADDR_WIDTH-1:0]          if_addr,
    input  logic [DATA_WIDTH-1:0]          if_wdata,
    output logic [DATA_WIDTH-1:0]          if_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [6:0]                     status_in,
    input  logic [DATA_WIDTH-1:0]          fifo_wdata,
    input  logic                           fifo_wr,
    output logic                           fifo_full
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic                  ovf_now;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q;
    logic                  push, pop;

    // Decode control-register writes to a one-hot select.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = if_wr && (if_addr == ADDR_WIDTH'(i));
        end
    end

    // Control registers and their write strobes; the strobe lines up with the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= if_wdata;
                end
            end
            wr_pulse_q <= wr_sel;
        end
    end

    // Flatten the register array onto the output bus.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign wr_pulse = wr_pulse_q;

    // FIFO handshake: a push while full is dropped even if a pop happens in the same cycle.
    always_comb begin
        push    = fifo_wr && !full_q;
        ovf_now = fifo_wr && full_q;
        pop     = if_rd && (if_addr == FIFO_ADDR) && (count_q != '0);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage, pointers, occupancy and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= fifo_wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
        end
    end

    assign fifo_full = full_q;

    // Sticky status next state; new events win over a host clear in the same cycle.
    always_comb begin
        status_d = status_q;
        if (if_wr && (if_addr == STATUS_ADDR)) begin
            status_d = status_q & ~if_wdata;
        end
        status_d = status_d | {ovf_now, status_in};
    end

    // Status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

`ifdef USB_REGB_FWID_EN
    logic [ADDR_WIDTH-1:0] fw_off;
    assign fw_off = if_addr - FW_BASE;
`endif

    // Read mux, purely combinational from the address.
    always_comb begin
        if_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (if_addr == ADDR_WIDTH'(i)) begin
                if_rdata = regs_q[i];
            end
        end
        if (if_addr == STATUS_ADDR) begin
            if_rdata = status_q;
        end
        if (if_addr == FIFO_ADDR) begin
            if_rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        end
        if (if_addr == FCNT_ADDR) begin
            if_rdata = DATA_WIDTH'(count_q);
        end
`ifdef USB_REGB_FWID_EN
        // Leftmost character of the string sits at FW_BASE.
        if (fw_off < ADDR_WIDTH'(16)) begin
            if_rdata = FW_ID[8*(15 - int'(fw_off)) +: 8];
        end
`endif
    end

endmodule

// File: tb/tb_usb_reg_bank.sv
// Self-checking bench for usb_reg_bank: directed steps followed by randomized traffic,
// checked against a queue/array reference model of the register bank.
module tb_usb_reg_bank;

    localparam int NR = 16;
    localparam int FD = 16;
    localparam logic [127:0] FW = "WOKAR_REGB_2.000";

    logic           clk = 1'b0;
    logic           rst;
    logic           if_wr, if_rd;
    logic [7:0]     if_addr, if_wdata, if_rdata;
    logic [NR*8-1:0] reg_out;
    logic [NR-1:0]  wr_pulse;
    logic [6:0]     status_in;
    logic [7:0]     fifo_wdata;
    logic           fifo_wr, fifo_full;

    usb_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .if_wr      (if_wr),
        .if_rd      (if_rd),
        .if_addr    (if_addr),
        .if_wdata   (if_wdata),
        .if_rdata   (if_rdata),
        .reg_out    (reg_out),
        .wr_pulse   (wr_pulse),
        .status_in  (status_in),
        .fifo_wdata (fifo_wdata),
        .fifo_wr    (fifo_wr),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0]    m_regs [NR];
    logic [NR-1:0] m_pulse;
    logic [7:0]    m_status;
    logic [7:0]    m_q [$];

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int k;
        if (int'(a) < NR) return m_regs[int'(a)];
        if (a == 8'hE0) return m_status;
        if (a == 8'hE1) return (m_q.size() != 0) ? m_q[0] : 8'h00;
        if (a == 8'hE2) return 8'(m_q.size());
`ifdef USB_REGB_FWID_EN
        if (a >= 8'hF0) begin
            k = int'(a) - 240;
            return FW[8*(15-k) +: 8];
        end
`endif
        k = 0;
        return 8'h00 + 8'(k);
    endfunction

    // Advance one clock and apply the bank's rules to the model with the inputs seen at the edge.
    task automatic tick();
        int       sz;
        logic     ovf;
        logic [7:0] ev;
        sz  = m_q.size();
        ovf = fifo_wr && (sz == FD);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
            m_pulse  = '0;
            m_status = 8'h00;
            m_q.delete();
        end else begin
            ev = {ovf, status_in};
            if (if_wr && (if_addr == 8'hE0)) m_status = (m_status & ~if_wdata) | ev;
            else m_status = m_status | ev;
            m_pulse = '0;
            if (if_wr && int'(if_addr) < NR) begin
                m_regs[int'(if_addr)] = if_wdata;
                m_pulse[int'(if_addr)] = 1'b1;
            end
            if (if_rd && if_addr == 8'hE1 && sz != 0) void'(m_q.pop_front());
            if (fifo_wr && sz < FD) m_q.push_back(fifo_wdata);
        end
        #1;
    endtask

    task automatic check_outputs();
        logic [NR*8-1:0] packed_regs;
        for (int i = 0; i < NR; i++) packed_regs[8*i +: 8] = m_regs[i];
        chk("reg_out", reg_out, packed_regs);
        chk("wr_pulse", wr_pulse, m_pulse);
        chk("fifo_full", fifo_full, m_q.size() == FD);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a);
        if_addr = a;
        #1;
        chk(tag, if_rdata, m_read(a));
    endtask

    initial begin
        int phase;
        rst = 1'b1; if_wr = 0; if_rd = 0; if_addr = 0; if_wdata = 0;
        status_in = 0; fifo_wdata = 0; fifo_wr = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check_outputs();
        chk("rst_fifo_full", fifo_full, 1'b0);
        for (int a = 0; a < NR; a++) rd_check("rst_reg", 8'(a));
        rd_check("rst_status", 8'hE0);
        chk("rst_status_zero", if_rdata, 8'h00);
        rd_check("rst_fifo", 8'hE1);
        rd_check("rst_fcnt", 8'hE2);
        chk("rst_fcnt_zero", if_rdata, 8'h00);

        // Control write and strobe.
        if_addr = 8'h03; if_wdata = 8'hA5; if_wr = 1; tick(); if_wr = 0;
        check_outputs();
        chk("reg3_value", reg_out[31:24], 8'hA5);
        chk("reg3_pulse", wr_pulse, 16'h0008);
        tick();
        chk("pulse_one_cycle", wr_pulse, 16'h0000);
        if_addr = 8'hD0; if_wdata = 8'h77; if_wr = 1; tick(); if_wr = 0;
        check_outputs();
        chk("unmapped_no_pulse", wr_pulse, 16'h0000);
        if_addr = 8'hE2; if_wdata = 8'h09; if_wr = 1; tick(); if_wr = 0;
        rd_check("fcnt_write_ignored", 8'hE2);

        // Sticky status, write-1-to-clear, set wins.
        status_in = 7'h04; tick(); status_in = 0;
        rd_check("status_set", 8'hE0);
        chk("status_0x04", if_rdata, 8'h04);
        tick();
        rd_check("status_sticky", 8'hE0);
        if_addr = 8'hE0; if_wdata = 8'h04; if_wr = 1; tick(); if_wr = 0;
        rd_check("status_clear", 8'hE0);
        chk("status_cleared_0", if_rdata, 8'h00);
        if_addr = 8'hE0; if_wdata = 8'h04; if_wr = 1; status_in = 7'h04; tick();
        if_wr = 0; status_in = 0;
        rd_check("status_set_wins", 8'hE0);
        chk("status_still_04", if_rdata, 8'h04);
        if_addr = 8'hE0; if_wdata = 8'hFF; if_wr = 1; tick(); if_wr = 0;

        // Fill, overflow, drain.
        for (int i = 0; i < FD; i++) begin
            fifo_wdata = 8'(8'h10 + i); fifo_wr = 1; tick();
        end
        fifo_wr = 0;
        check_outputs();
        chk("fifo_full_16", fifo_full, 1'b1);
        rd_check("fcnt_16", 8'hE2);
        chk("fcnt_is_16", if_rdata, 8'd16);
        fifo_wdata = 8'h55; fifo_wr = 1; tick(); fifo_wr = 0;
        rd_check("ovf_status", 8'hE0);
        chk("ovf_bit7", if_rdata[7], 1'b1);
        for (int i = 0; i < FD; i++) begin
            rd_check("drain_head", 8'hE1);
            chk("drain_order", if_rdata, 8'(8'h10 + i));
            if_rd = 1; tick(); if_rd = 0;
        end
        rd_check("empty_head", 8'hE1);
        chk("empty_head_zero", if_rdata, 8'h00);
        rd_check("empty_fcnt", 8'hE2);
        if_addr = 8'hE1; if_rd = 1; tick(); if_rd = 0;
        rd_check("pop_empty_ignored", 8'hE2);
        check_outputs();

        // Simultaneous push+pop across the pointer wrap.
        for (int i = 0; i < 5; i++) begin
            fifo_wdata = 8'(8'h30 + i); fifo_wr = 1; tick();
        end
        for (int i = 0; i < 20; i++) begin
            if_addr = 8'hE1; if_rd = 1; fifo_wdata = 8'(8'h40 + i); fifo_wr = 1; tick();
            if_rd = 0; fifo_wr = 0;
            rd_check("pp_count", 8'hE2);
            rd_check("pp_head", 8'hE1);
        end
        chk("pp_count_5", if_rdata, 8'h00 + 8'(8'h40 + 15));

        // Firmware ID window.
        for (int k = 0; k < 16; k++) rd_check("fw_byte", 8'(8'hF0 + k));
`ifdef USB_REGB_FWID_EN
        if_addr = 8'hF0; #1; chk("fw_first_W", if_rdata, 8'h57);
`else
        if_addr = 8'hF0; #1; chk("fw_first_zero", if_rdata, 8'h00);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            phase = (n / 75) % 2;
            case ($urandom_range(0, 5))
                0, 1:    if_addr = 8'($urandom_range(0, NR - 1));
                2:       if_addr = 8'hE0;
                3:       if_addr = 8'hE1;
                4:       if_addr = 8'hE2;
                default: if_addr = 8'($urandom_range(0, 255));
            endcase
            if_wr      = ($urandom_range(0, 3) == 0);
            if_wdata   = 8'($urandom);
            if_rd      = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fifo_wr    = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fifo_wdata = 8'($urandom);
            status_in  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00;
            tick();
            if_wr = 0; if_rd = 0; fifo_wr = 0; status_in = 0;
            check_outputs();
            rd_check("rand_read", if_addr);
            rd_check("rand_status", 8'hE0);
            rd_check("rand_fcnt", 8'hE2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
